bus_arbiter_n: RTL and testbench

- Parametrised N-master to 1-slave arbiter for the valid/ready memory bus used by the core, DMA and debug ports.
- Each master and the slave use the same handshake:
  - a request is held stable with valid high until ready.
  - ready is high for exactly one cycle per completed transfer.
- Fair round-robin grant with registered routing. Back-to-back handoff between masters with no idle cycle.
- Sits between the masters and a single memory/peripheral slave.

---
 rtl/bus_arbiter_n.sv | 143 ++++++++++++++
 tb/tb_bus_arbiter_n.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_n.sv
// N-master to 1-slave round-robin arbiter for the valid/ready memory bus.
// Optional grant lock for atomic sequences: define BUS_ARBITER_N_LOCK_EN.
module bus_arbiter_n #(
   parameter int unsigned  NUM_MASTERS = 4,
   parameter int unsigned  ADDR_WIDTH  = 32,
   parameter int unsigned  DATA_WIDTH  = 32,
   localparam int unsigned GW = ($clog2(NUM_MASTERS) > 1) ? $clog2(NUM_MASTERS) : 1,
   localparam int unsigned SW = DATA_WIDTH / 8
) (
   input  logic                              clk,
   input  logic                              resetn,
   input  logic [NUM_MASTERS-1:0]            m_valid,
   output logic [NUM_MASTERS-1:0]            m_ready,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
   input  logic [NUM_MASTERS*SW-1:0]         m_wstrb,
`ifdef BUS_ARBITER_N_LOCK_EN
   input  logic [NUM_MASTERS-1:0]            m_lock,
`endif
   output logic [DATA_WIDTH-1:0]             m_rdata,
   output logic                              s_valid,
   input  logic                              s_ready,
   output logic [ADDR_WIDTH-1:0]             s_addr,
   output logic [DATA_WIDTH-1:0]             s_wdata,
   output logic [SW-1:0]                     s_wstrb,
   input  logic [DATA_WIDTH-1:0]             s_s_rdata,
   output logic [GW-1:0]                     grant_id
);

   localparam int unsigned N = NUM_MASTERS;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1
   } state_t;

   state_t        state, state_nx;
   logic [GW-1:0] grant, grant_nx;
   logic [GW-1:0] last, last_nx;
   logic [N-1:0]  req_others;
   logic [GW:0]   pick_idle, pick_busy;
   logic          keep;
`ifdef BUS_ARBITER_N_LOCK_EN
   logic          cur_valid, cur_lock;
`endif

   // First set bit of req searching from+1, from+2, ... modulo N; MSB flags a hit.
   function automatic logic [GW:0] rr_pick(input logic [N-1:0] req, input logic [GW-1:0] from);
      logic [GW:0] res;
      int unsigned cand;
      res = '0;
      for (int unsigned k = 1; k <= N; k++) begin
         cand = (32'(from) + k) % N;
         if (!res[GW] && req[cand]) res = {1'b1, GW'(cand)};
      end
      return res;
   endfunction

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= ST_IDLE;
         grant <= '0;
         last  <= GW'(N - 1);
      end else begin
         state <= state_nx;
         grant <= grant_nx;
         last  <= last_nx;
      end
   end

   // Next owner: the completing master is excluded so its still-high valid cannot re-win.
   always_comb begin
      state_nx   = state;
      grant_nx   = grant;
      last_nx    = last;
      req_others = m_valid;
`ifdef BUS_ARBITER_N_LOCK_EN
      cur_valid  = 1'b0;
      cur_lock   = 1'b0;
`endif
      for (int i = 0; i < int'(N); i++) begin
         if (grant == GW'(i)) begin
            req_others[i] = 1'b0;
`ifdef BUS_ARBITER_N_LOCK_EN
            cur_valid     = m_valid[i];
            cur_lock      = m_lock[i];
`endif
         end
      end
`ifdef BUS_ARBITER_N_LOCK_EN
      keep = cur_lock & cur_valid;
`else
      keep = 1'b0;
`endif
      pick_idle = rr_pick(m_valid, last);
      pick_busy = rr_pick(req_others, last);
      case (state)
         ST_IDLE: begin
            if (pick_idle[GW]) begin
               state_nx = ST_BUSY;
               grant_nx = pick_idle[GW-1:0];
               last_nx  = pick_idle[GW-1:0];
            end
         end
         ST_BUSY: begin
            if (s_ready && !keep) begin
               if (pick_busy[GW]) begin
                  grant_nx = pick_busy[GW-1:0];
                  last_nx  = pick_busy[GW-1:0];
               end else begin
                  state_nx = ST_IDLE;
               end
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Routing from the registered owner; everything reads zero outside BUSY.
   always_comb begin
      s_valid  = 1'b0;
      m_ready  = '0;
      s_addr   = '0;
      s_wdata  = '0;
      s_wstrb  = '0;
      grant_id = '0;
      if (state == ST_BUSY) begin
         s_valid  = 1'b1;
         grant_id = grant;
         for (int i = 0; i < int'(N); i++) begin
            if (grant == GW'(i)) begin
               m_ready[i] = s_ready;
               s_addr     = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
               s_wdata    = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
               s_wstrb    = m_wstrb[i*SW +: SW];
            end
         end
      end
   end

   assign m_rdata = s_s_rdata;

endmodule

// File: tb/tb_bus_arbiter_n.sv
// Directed bench for bus_arbiter_n with a completion scoreboard.
// Lock scenario is compiled in when BUS_ARBITER_N_LOCK_EN is defined.
module tb_bus_arbiter_n;

   localparam int unsigned N  = 4;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = DW / 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          resetn;
   logic [N-1:0]  mv;
   logic          sr;
   logic [DW-1:0] rd;
   logic [AW-1:0] a  [N];
   logic [DW-1:0] wd [N];
   logic [SW-1:0] ws [N];
`ifdef BUS_ARBITER_N_LOCK_EN
   logic [N-1:0]  lk;
`endif

   logic [N*AW-1:0] m_addr;
   logic [N*DW-1:0] m_wdata;
   logic [N*SW-1:0] m_wstrb;
   logic [N-1:0]    m_ready;
   logic [DW-1:0]   m_rdata;
   logic            s_valid;
   logic [AW-1:0]   s_addr;
   logic [DW-1:0]   s_wdata;
   logic [SW-1:0]   s_wstrb;
   logic [1:0]      grant_id;

   always_comb begin
      for (int i = 0; i < int'(N); i++) begin
         m_addr[i*AW +: AW]  = a[i];
         m_wdata[i*DW +: DW] = wd[i];
         m_wstrb[i*SW +: SW] = ws[i];
      end
   end

   bus_arbiter_n dut (
      .clk       (clk),
      .resetn    (resetn),
      .m_valid   (mv),
      .m_ready   (m_ready),
      .m_addr    (m_addr),
      .m_wdata   (m_wdata),
      .m_wstrb   (m_wstrb),
`ifdef BUS_ARBITER_N_LOCK_EN
      .m_lock    (lk),
`endif
      .m_rdata   (m_rdata),
      .s_valid   (s_valid),
      .s_ready   (sr),
      .s_addr    (s_addr),
      .s_wdata   (s_wdata),
      .s_wstrb   (s_wstrb),
      .s_s_rdata (rd),
      .grant_id  (grant_id)
   );

   typedef struct {
      int unsigned   g;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [SW-1:0] wstrb;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Expected completion, captured from the master's request as driven now.
   task automatic push(input int unsigned g);
      sb.push_back('{g, a[g], wd[g], ws[g]});
   endtask

   task automatic next();
      @(posedge clk);
      #1;
      rd = DW'($urandom);
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      mv     = '0;
      sr     = 1'b0;
`ifdef BUS_ARBITER_N_LOCK_EN
      lk     = '0;
`endif
      next();
      next();
      resetn = 1'b1;
   endtask

   // Scoreboard side: every completion pops one expectation; otherwise no m_ready.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (s_valid && sr) begin
         check("sb_nonempty", 128'(sb.size() != 0), 128'(1));
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("sb_grant_id", 128'(grant_id), 128'(e.g));
            check("sb_m_ready", 128'(m_ready), 128'(4'b0001 << e.g));
            check("sb_s_addr", 128'(s_addr), 128'(e.addr));
            check("sb_s_wdata", 128'(s_wdata), 128'(e.wdata));
            check("sb_s_wstrb", 128'(s_wstrb), 128'(e.wstrb));
         end
      end else begin
         check("no_m_ready", 128'(m_ready), 128'(0));
         if (!s_valid)
            check("idle_routes_zero", 128'({s_addr, s_wdata, s_wstrb, grant_id}), 128'(0));
      end
      check("m_rdata_pass", 128'(m_rdata), 128'(rd));
   end

   initial begin
      resetn = 1'b0;
      mv     = '0;
      sr     = 1'b0;
      rd     = '0;
`ifdef BUS_ARBITER_N_LOCK_EN
      lk     = '0;
`endif
      for (int i = 0; i < int'(N); i++) begin
         a[i]  = AW'(32'h1000 + i * 16);
         wd[i] = DW'(32'hA5A5_0000 + i);
         ws[i] = SW'(i + 1);
      end

      mid();
      check("rst_s_valid", 128'(s_valid), 128'(0));
      check("rst_grant_id", 128'(grant_id), 128'(0));
      next();
      next();
      resetn = 1'b1;

      // Single read from master 0, slave completes in cycle 3.
      a[0]  = 32'h100;
      ws[0] = '0;
      mv    = 4'b0001;
      push(0);
      mid(); check("t1_c0_s_valid", 128'(s_valid), 128'(0)); next();
      mid();
      check("t1_c1_s_valid", 128'(s_valid), 128'(1));
      check("t1_c1_grant_id", 128'(grant_id), 128'(0));
      check("t1_c1_s_addr", 128'(s_addr), 128'(32'h100));
      next();
      mid(); next();
      sr = 1'b1;
      mid(); next();
      mv = '0;
      sr = 1'b0;
      mid(); check("t1_c4_idle", 128'(s_valid), 128'(0)); next();
      check("t1_sb_empty", 128'(sb.size()), 128'(0));

      // All four masters, slave always ready: rotation with no bubble.
      do_reset();
      for (int k = 0; k < 8; k++) push(k % 4);
      mv = 4'b1111;
      sr = 1'b1;
      mid(); check("t2_c0_s_valid", 128'(s_valid), 128'(0)); next();
      for (int c = 1; c <= 8; c++) begin
         if (c == 8) mv = 4'b1000;
         mid(); check("t2_s_valid_held", 128'(s_valid), 128'(1)); next();
      end
      mv = '0;
      sr = 1'b0;
      mid(); check("t2_end_idle", 128'(s_valid), 128'(0)); next();
      check("t2_sb_empty", 128'(sb.size()), 128'(0));

      // Write from master 2; other masters carry different data.
      ws[2] = 4'b0011;
      wd[2] = 32'hDEAD_BEEF;
      mv    = 4'b0100;
      push(2);
      mid(); next();
      mid();
      check("t3_s_wstrb", 128'(s_wstrb), 128'(4'b0011));
      check("t3_s_wdata", 128'(s_wdata), 128'(32'hDEAD_BEEF));
      check("t3_grant_id", 128'(grant_id), 128'(2));
      next();
      sr = 1'b1;
      mid(); next();
      mv = '0;
      sr = 1'b0;
      mid(); check("t3_end_idle", 128'(s_valid), 128'(0)); next();
      check("t3_sb_empty", 128'(sb.size()), 128'(0));

      // Masters 1 and 3: 3 must be served before 1 returns.
      mv = 4'b0010;
      push(1);
      mid(); next();
      mv = 4'b1010;
      sr = 1'b1;
      push(3);
      mid(); check("t4_c1_grant_id", 128'(grant_id), 128'(1)); next();
      a[1] = 32'h2220;
      push(1);
      mid(); check("t4_c2_grant_id", 128'(grant_id), 128'(3)); next();
      mv = 4'b0010;
      mid(); check("t4_c3_grant_id", 128'(grant_id), 128'(1)); next();
      mv = '0;
      sr = 1'b0;
      mid(); check("t4_end_idle", 128'(s_valid), 128'(0)); next();
      check("t4_sb_empty", 128'(sb.size()), 128'(0));

      // Reset in the middle of a transfer aborts it without m_ready.
      mv = 4'b0100;
      mid(); next();
      mid(); check("t5_busy", 128'(s_valid), 128'(1)); next();
      resetn = 1'b0;
      #1;
      check("t5_abort_s_valid", 128'(s_valid), 128'(0));
      check("t5_abort_m_ready", 128'(m_ready), 128'(0));
      sr = 1'b1;
      #1;
      check("t5_rst_ready_m_ready", 128'(m_ready), 128'(0));
      mv = 4'b1111;
      mid(); next();
      resetn = 1'b1;
      for (int k = 0; k < 4; k++) push(k);
      mid(); check("t5_release_idle", 128'(s_valid), 128'(0)); next();
      mid(); check("t5_first_grant", 128'(grant_id), 128'(0)); next();
      mid(); next();
      mid(); next();
      mv = 4'b1000;
      mid(); next();
      mv = '0;
      sr = 1'b0;
      mid(); check("t5_end_idle", 128'(s_valid), 128'(0)); next();
      check("t5_sb_empty", 128'(sb.size()), 128'(0));

`ifdef BUS_ARBITER_N_LOCK_EN
      // Master 1 locks across three transfers while master 2 waits.
      do_reset();
      mv = 4'b0110;
      lk = 4'b0010;
      push(1);
      push(1);
      push(1);
      push(2);
      mid(); next();
      sr = 1'b1;
      mid(); check("t6_c1_grant_id", 128'(grant_id), 128'(1)); next();
      mid(); check("t6_c2_grant_id", 128'(grant_id), 128'(1)); next();
      lk = '0;
      mid(); check("t6_c3_grant_id", 128'(grant_id), 128'(1)); next();
      mv = 4'b0100;
      mid(); check("t6_c4_grant_id", 128'(grant_id), 128'(2)); next();
      mv = '0;
      sr = 1'b0;
      mid(); check("t6_end_idle", 128'(s_valid), 128'(0)); next();
      check("t6_sb_empty", 128'(sb.size()), 128'(0));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
